// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the LC-3b pipeline hazard controller: FSM states, the
// register-control word and the load-use detector.
package pipe_hazard_ctrl_pkg;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_IND2 = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic load_pc;
        logic load_ifid;
        logic load_idex;
        logic load_exme;
        logic load_mewb;
        logic bub_ifid;
        logic bub_idex;
        logic bub_exme;
        logic bub_mewb;
        logic pc_sel;
    } pipe_ctrl_t;

    // Field order: loads pc/ifid/idex/exme/mewb, bubbles ifid/idex/exme/mewb, pc_sel.
    localparam pipe_ctrl_t CTRL_INIT  = 10'b01111_1111_0;
    localparam pipe_ctrl_t CTRL_RUN   = 10'b11111_0000_0;
    localparam pipe_ctrl_t CTRL_HOLD  = 10'b00001_0001_0;
    localparam pipe_ctrl_t CTRL_REDIR = 10'b11111_1110_1;

    function automatic logic load_use(input lc3b_reg src1, input lc3b_reg src2,
                                      input logic use1, input logic use2,
                                      input lc3b_reg dest, input logic memrd);
        return memrd && ((use1 && (src1 == dest)) || (use2 && (src2 == dest)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipe: drives pipe register
// load/bubble selects and PC load/source from hazard and memory handshakes.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int INIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  lc3b_reg          ifid_src1,
    input  lc3b_reg          ifid_src2,
    input  logic             ifid_use1,
    input  logic             ifid_use2,
    input  lc3b_reg          idex_dest,
    input  logic             idex_memrd,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             exme_indirect,
    input  logic             br_taken,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exme,
    output logic             load_mewb,
    output logic             bub_ifid,
    output logic             bub_idex,
    output logic             bub_exme,
    output logic             bub_mewb,
    output logic             pc_sel,
    output logic             dmem_phase,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

    pipe_state_t    state_q, state_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    pipe_ctrl_t     ctrl;
    logic           phase;
    logic           stall_inc, flush_inc;
    logic           dwait, iwait, luse;

    assign dwait = dmem_req && !dmem_resp;
    assign iwait = imem_read && !imem_resp;
    assign luse  = load_use(ifid_src1, ifid_src2, ifid_use1, ifid_use2, idex_dest, idex_memrd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ctrl       = CTRL_RUN;
        phase      = 1'b0;
        flush_inc  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                ctrl = CTRL_INIT;
                if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
                else                         init_cnt_d = init_cnt_q + ICW'(1);
            end
            ST_RUN: begin
                if (dwait) begin
                    ctrl = CTRL_HOLD;
                end else if (dmem_req && exme_indirect) begin
                    // First half of LDI/STI done; pointer access still to come.
                    ctrl    = CTRL_HOLD;
                    state_d = ST_IND2;
                end else if (br_taken) begin
                    if (iwait) begin
                        ctrl = CTRL_HOLD;
                    end else begin
                        ctrl      = CTRL_REDIR;
                        flush_inc = 1'b1;
                    end
                end else if (luse) begin
                    ctrl.load_pc   = 1'b0;
                    ctrl.load_ifid = 1'b0;
                    ctrl.bub_idex  = 1'b1;
                end else if (iwait) begin
                    ctrl.load_pc  = 1'b0;
                    ctrl.bub_ifid = 1'b1;
                end
            end
            ST_IND2: begin
                phase = 1'b1;
                if (!dmem_resp) ctrl = CTRL_HOLD;
                else            state_d = ST_RUN;
            end
            default: begin
                ctrl    = CTRL_INIT;
                state_d = ST_INIT;
            end
        endcase
    end

    assign stall_inc = (state_q != ST_INIT) && !ctrl.load_pc;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(stall_inc), .cnt_o(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(flush_inc), .cnt_o(flush_cnt)
    );

    assign load_pc    = ctrl.load_pc;
    assign load_ifid  = ctrl.load_ifid;
    assign load_idex  = ctrl.load_idex;
    assign load_exme  = ctrl.load_exme;
    assign load_mewb  = ctrl.load_mewb;
    assign bub_ifid   = ctrl.bub_ifid;
    assign bub_idex   = ctrl.bub_idex;
    assign bub_exme   = ctrl.bub_exme;
    assign bub_mewb   = ctrl.bub_mewb;
    assign pc_sel     = ctrl.pc_sel;
    assign dmem_phase = phase;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 16-bit and a 4-bit counter instance share
// stimulus; outputs are checked against vector tables and a rule-level model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [2:0] src1, src2, dest;
        logic use1, use2, memrd, ird, iresp, dreq, dresp, ind, br;
    } in_t;

    // {load pc,ifid,idex,exme,mewb | bub ifid,idex,exme,mewb | pc_sel | dmem_phase}
    typedef logic [10:0] out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    localparam out_t B_INIT  = 11'b01111_1111_0_0;
    localparam out_t B_RUN   = 11'b11111_0000_0_0;
    localparam out_t B_HOLD  = 11'b00001_0001_0_0;
    localparam out_t B_REDIR = 11'b11111_1110_1_0;
    localparam out_t B_LU    = 11'b00111_0100_0_0;
    localparam out_t B_IW    = 11'b01111_1000_0_0;
    localparam out_t B_HOLD2 = 11'b00001_0001_0_1;
    localparam out_t B_RUN2  = 11'b11111_0000_0_1;
    localparam int   INITC   = 1;

    logic clk = 1'b0;
    logic rst_n;
    in_t  in;
    always #5 clk = ~clk;

    logic        lpc_a, lif_a, lid_a, lex_a, lmw_a, bif_a, bid_a, bex_a, bmw_a, sel_a, ph_a;
    logic        lpc_b, lif_b, lid_b, lex_b, lmw_b, bif_b, bid_b, bex_b, bmw_b, sel_b, ph_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;
    out_t        o_a, o_b;

    assign o_a = {lpc_a, lif_a, lid_a, lex_a, lmw_a, bif_a, bid_a, bex_a, bmw_a, sel_a, ph_a};
    assign o_b = {lpc_b, lif_b, lid_b, lex_b, lmw_b, bif_b, bid_b, bex_b, bmw_b, sel_b, ph_b};

    pipe_hazard_ctrl #(.CNT_W(16), .INIT_CYCLES(INITC)) u_a (
        .clk(clk), .rst_n(rst_n),
        .ifid_src1(in.src1), .ifid_src2(in.src2), .ifid_use1(in.use1), .ifid_use2(in.use2),
        .idex_dest(in.dest), .idex_memrd(in.memrd), .imem_read(in.ird), .imem_resp(in.iresp),
        .dmem_req(in.dreq), .dmem_resp(in.dresp), .exme_indirect(in.ind), .br_taken(in.br),
        .load_pc(lpc_a), .load_ifid(lif_a), .load_idex(lid_a), .load_exme(lex_a), .load_mewb(lmw_a),
        .bub_ifid(bif_a), .bub_idex(bid_a), .bub_exme(bex_a), .bub_mewb(bmw_a),
        .pc_sel(sel_a), .dmem_phase(ph_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .INIT_CYCLES(INITC)) u_b (
        .clk(clk), .rst_n(rst_n),
        .ifid_src1(in.src1), .ifid_src2(in.src2), .ifid_use1(in.use1), .ifid_use2(in.use2),
        .idex_dest(in.dest), .idex_memrd(in.memrd), .imem_read(in.ird), .imem_resp(in.iresp),
        .dmem_req(in.dreq), .dmem_resp(in.dresp), .exme_indirect(in.ind), .br_taken(in.br),
        .load_pc(lpc_b), .load_ifid(lif_b), .load_idex(lid_b), .load_exme(lex_b), .load_mewb(lmw_b),
        .bub_ifid(bif_b), .bub_idex(bid_b), .bub_exme(bex_b), .bub_mewb(bmw_b),
        .pc_sel(sel_b), .dmem_phase(ph_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference state: cycles of INIT left, second indirect access pending, raw event counts.
    int init_left;
    bit m_ind2;
    int m_stall, m_flush;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int s1, input int s2, input int d, input bit u1, input bit u2,
                               input bit mr, input bit ir, input bit irs, input bit dr,
                               input bit drs, input bit ind, input bit br);
        in_t r;
        r.src1 = 3'(s1); r.src2 = 3'(s2); r.dest = 3'(d);
        r.use1 = u1; r.use2 = u2; r.memrd = mr; r.ird = ir; r.iresp = irs;
        r.dreq = dr; r.dresp = drs; r.ind = ind; r.br = br;
        return r;
    endfunction

    function automatic out_t model(input in_t i);
        bit dw, iw, lu;
        out_t r;
        dw = i.dreq && !i.dresp;
        iw = i.ird && !i.iresp;
        lu = i.memrd && ((i.use1 && i.src1 == i.dest) || (i.use2 && i.src2 == i.dest));
        if (init_left > 0) return B_INIT;
        if (m_ind2) begin
            r = i.dresp ? B_RUN : B_HOLD;
            r[0] = 1'b1;
            return r;
        end
        if (dw) return B_HOLD;
        if (i.dreq && i.ind) return B_HOLD;
        if (i.br) return iw ? B_HOLD : B_REDIR;
        if (lu) return B_LU;
        if (iw) return B_IW;
        return B_RUN;
    endfunction

    task automatic advance(input in_t i);
        out_t e;
        e = model(i);
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (!e[10]) m_stall++;
            if (!m_ind2 && e[1]) m_flush++;
            if (m_ind2) begin
                if (i.dresp) m_ind2 = 1'b0;
            end else if (i.dreq && i.dresp && i.ind) begin
                m_ind2 = 1'b1;
            end
        end
    endtask

    task automatic check_cnts(input string name);
        check({name, ".stall16"}, stall_a, 16'((m_stall > 65535) ? 65535 : m_stall));
        check({name, ".flush16"}, flush_a, 16'((m_flush > 65535) ? 65535 : m_flush));
        check({name, ".stall4"}, {12'd0, stall_b}, 16'((m_stall > 15) ? 15 : m_stall));
        check({name, ".flush4"}, {12'd0, flush_b}, 16'((m_flush > 15) ? 15 : m_flush));
    endtask

    // Apply one cycle of inputs just after a rising edge; check at the falling edge.
    task automatic step(input string name, input in_t i, input out_t e);
        in = i;
        @(negedge clk);
        check({name, ".ctl16"}, {5'd0, o_a}, {5'd0, e});
        check({name, ".ctl4"},  {5'd0, o_b}, {5'd0, e});
        check_cnts(name);
        @(posedge clk);
        advance(i);
        #1;
    endtask

    task automatic step_m(input string name, input in_t i);
        step(name, i, model(i));
    endtask

    task automatic model_reset();
        init_left = INITC;
        m_ind2    = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    in_t  idle, i_tmp;
    vec_t tbl[$];
    int   s0, f0;

    initial begin
        idle  = '0;
        in    = '0;
        rst_n = 1'b0;
        model_reset();

        // Reset held 3 cycles with noisy inputs: INIT decode throughout, counters zero.
        in = mk(3, 3, 3, 1, 1, 1, 1, 0, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst.ctl16", {5'd0, o_a}, {5'd0, B_INIT});
            check("rst.stall", stall_a, 16'd0);
            check("rst.flush", flush_a, 16'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("init", idle, B_INIT);
        step("run0", idle, B_RUN);

        tbl.push_back('{"idle",     mk(0,0,0, 0,0,0, 0,0, 0,0,0,0), B_RUN});
        tbl.push_back('{"lu_src1",  mk(3,1,3, 1,0,1, 1,1, 0,0,0,0), B_LU});
        tbl.push_back('{"lu_src2",  mk(1,5,5, 0,1,1, 1,1, 0,0,0,0), B_LU});
        tbl.push_back('{"nouse1",   mk(3,1,3, 0,0,1, 1,1, 0,0,0,0), B_RUN});
        tbl.push_back('{"nomemrd",  mk(3,3,3, 1,1,0, 1,1, 0,0,0,0), B_RUN});
        tbl.push_back('{"imiss",    mk(0,0,0, 0,0,0, 1,0, 0,0,0,0), B_IW});
        tbl.push_back('{"lu_imiss", mk(2,0,2, 1,0,1, 1,0, 0,0,0,0), B_LU});
        tbl.push_back('{"dwait",    mk(0,0,0, 0,0,0, 1,1, 1,0,0,0), B_HOLD});
        tbl.push_back('{"dw_br_lu", mk(4,4,4, 1,1,1, 1,0, 1,0,1,1), B_HOLD});
        tbl.push_back('{"br",       mk(0,0,0, 0,0,0, 1,1, 0,0,0,1), B_REDIR});
        tbl.push_back('{"br_imiss", mk(0,0,0, 0,0,0, 1,0, 0,0,0,1), B_HOLD});
        tbl.push_back('{"br_lu",    mk(6,0,6, 1,0,1, 0,0, 0,0,0,1), B_REDIR});
        tbl.push_back('{"dmem_ok",  mk(0,0,0, 0,0,0, 1,1, 1,1,0,0), B_RUN});
        foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].e);

        // Load-use: a single stall cycle.
        s0 = m_stall;
        step("lu", mk(3,0,3, 1,0,1, 1,1, 0,0,0,0), B_LU);
        step("lu_after", idle, B_RUN);
        check("lu.stall_delta", stall_a, 16'(s0 + 1));

        // Data wait for 4 cycles then completion.
        s0 = m_stall;
        for (int k = 0; k < 4; k++) step("dwait4", mk(0,0,0, 0,0,0, 1,1, 1,0,0,0), B_HOLD);
        step("dwait_done", mk(0,0,0, 0,0,0, 1,1, 1,1,0,0), B_RUN);
        check("dwait.stall_delta", stall_a, 16'(s0 + 4));

        // LDI: first response after 2 waits, second after 2 more; branch ignored in IND2.
        s0 = m_stall;
        for (int k = 0; k < 2; k++) step("ldi_w1", mk(0,0,0, 0,0,0, 1,1, 1,0,1,0), B_HOLD);
        step("ldi_r1", mk(0,0,0, 0,0,0, 1,1, 1,1,1,0), B_HOLD);
        for (int k = 0; k < 2; k++) step("ldi_w2", mk(0,0,0, 0,0,0, 1,1, 1,0,1,1), B_HOLD2);
        step("ldi_r2", mk(0,0,0, 0,0,0, 1,1, 1,1,1,1), B_RUN2);
        step("ldi_after", idle, B_RUN);
        check("ldi.stall_delta", stall_a, 16'(s0 + 5));

        // Redirect immediately, then one waiting on fetch for 2 cycles.
        f0 = m_flush;
        step("br_now", mk(0,0,0, 0,0,0, 1,1, 0,0,0,1), B_REDIR);
        check("br.flush_delta", flush_a, 16'(f0 + 1));
        for (int k = 0; k < 2; k++) step("br_wait", mk(0,0,0, 0,0,0, 1,0, 0,0,0,1), B_HOLD);
        step("br_late", mk(0,0,0, 0,0,0, 1,1, 0,0,0,1), B_REDIR);
        check("br.flush_delta2", flush_a, 16'(f0 + 2));

        // Reset asserted mid-indirect: INIT decode immediately, counters cleared.
        step("ind_enter", mk(0,0,0, 0,0,0, 1,1, 1,1,1,0), B_HOLD);
        in = mk(0,0,0, 0,0,0, 1,1, 1,0,1,0);
        rst_n = 1'b0;
        #1;
        check("midrst.ctl16", {5'd0, o_a}, {5'd0, B_INIT});
        check("midrst.ctl4",  {5'd0, o_b}, {5'd0, B_INIT});
        check("midrst.stall", stall_a, 16'd0);
        check("midrst.flush", flush_a, 16'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("reinit", idle, B_INIT);

        // Saturation: 20 fetch-miss stalls, 4-bit counter must stop at 15.
        for (int k = 0; k < 20; k++) step("sat", mk(0,0,0, 0,0,0, 1,0, 0,0,0,0), B_IW);
        check("sat.stall4", {12'd0, stall_b}, 16'd15);
        check("sat.stall16", stall_a, 16'd20);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            i_tmp.src1  = 3'($urandom_range(0, 3));
            i_tmp.src2  = 3'($urandom_range(0, 3));
            i_tmp.dest  = 3'($urandom_range(0, 3));
            i_tmp.use1  = ($urandom_range(0, 99) < 60);
            i_tmp.use2  = ($urandom_range(0, 99) < 40);
            i_tmp.memrd = ($urandom_range(0, 99) < 40);
            i_tmp.ird   = ($urandom_range(0, 99) < 70);
            i_tmp.iresp = ($urandom_range(0, 99) < 60);
            i_tmp.dreq  = ($urandom_range(0, 99) < 30);
            i_tmp.dresp = ($urandom_range(0, 99) < 50);
            i_tmp.ind   = ($urandom_range(0, 99) < 30);
            i_tmp.br    = ($urandom_range(0, 99) < 15);
            step_m("rand", i_tmp);
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
